// File: rtl/l2_port_arbiter_if.sv
// Bundle between the two L1 miss ports, the arbiter and the L2 upstream port.
// The arbiter takes the slave modport; the L1/L2 environment takes the master modport.
interface l2_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // Handshake: a requester raises x_read/x_write and holds x_addr/x_wdata stable
  // until the cycle x_resp=1, then drops its request on the following cycle.
  // Toward the L2, l2_read/l2_write stay high with l2_addr/l2_wdata stable until
  // the single-cycle l2_resp pulse; l2_rdata is valid only in that pulse cycle.
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Shares the L2 upstream port between the L1 I-cache and D-cache miss ports.
// Define L2_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module l2_port_arbiter (
  input  logic              clk,
  input  logic              rst,
  l2_port_arbiter_if.slave  bus,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  logic   d_req;
  logic   i_req;
  logic   pick_d;

  assign d_req = bus.d_read | bus.d_write;
  assign i_req = bus.i_read;

`ifdef L2_ARB_RR_EN
  logic last_d;  // 1 = D won the previous arbitration, 0 = I (reset value)

  assign pick_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_d) begin
        last_d <= 1'b1;
      end else if (i_req) begin
        last_d <= 1'b0;
      end
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.l2_read  <= 1'b0;
      bus.l2_write <= 1'b0;
      bus.l2_addr  <= '0;
      bus.l2_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state        <= GRANT_D;
            bus.l2_addr  <= bus.d_addr;
            bus.l2_wdata <= bus.d_wdata;
            // A write wins if the D side illegally raises both strobes.
            bus.l2_write <= bus.d_write;
            bus.l2_read  <= ~bus.d_write;
          end else if (i_req) begin
            state        <= GRANT_I;
            bus.l2_addr  <= bus.i_addr;
            bus.l2_write <= 1'b0;
            bus.l2_read  <= 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.l2_resp) begin
            state        <= DONE;
            bus.l2_read  <= 1'b0;
            bus.l2_write <= 1'b0;
          end
        end
        DONE: begin
          // One-cycle bubble so the winner's request has dropped before re-arbitration.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_resp  = bus.l2_resp & (state == GRANT_I);
  assign bus.d_resp  = bus.l2_resp & (state == GRANT_D);
  assign bus.i_rdata = bus.l2_rdata;
  assign bus.d_rdata = bus.l2_rdata;
  assign fsm_state   = state;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.d_read && bus.d_write))
    else $warning("d_read and d_write asserted together");

  a_resp_in_grant: assert property (@(posedge clk) disable iff (rst)
    bus.l2_resp |-> (state == GRANT_I || state == GRANT_D))
    else $warning("l2_resp outside a grant state, ignored");

endmodule
